// File: rtl/seq_decoder_pkg.sv
// Shared types and code generators for seq_decoder.
// Codes are built at the widest legal size (MAX_IN_W = 8, 256 outputs);
// users truncate the result to their own output width.
package seq_decoder_pkg;

    localparam int unsigned MAX_IN_W  = 8;
    localparam int unsigned MAX_OUT_W = 1 << MAX_IN_W;

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } state_e;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERMO = 1'b1;

    // Bit sel set, all others clear.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction

    // Bits 0..sel set. For sel = MAX_OUT_W-1 the shift overflows to zero,
    // so the subtraction still yields all ones.
    function automatic logic [MAX_OUT_W-1:0] thermo(input logic [MAX_IN_W-1:0] sel);
        return (MAX_OUT_W'(2) << sel) - MAX_OUT_W'(1);
    endfunction

endpackage

// File: rtl/seq_decoder_scan_ctr.sv
// Scan position generator: a dwell counter that holds each position for
// DWELL cycles, and a scan index that wraps naturally at 2**IN_W.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : return dwell and scan_idx to 0 (wins over en)
//   en          : advance the dwell counter this cycle
//   step_c      : combinational; scan_idx advances at the coming edge
//   scan_idx    : registered scan position
module seq_decoder_scan_ctr
    import seq_decoder_pkg::*;
#(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    output logic            step_c,
    output logic [IN_W-1:0] scan_idx
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [IN_W-1:0] scan_idx_q, scan_idx_d;

    assign step_c   = en && !clr && (dwell_q == DW_W'(DWELL - 1));
    assign scan_idx = scan_idx_q;

    // Next-state for the dwell counter and scan index.
    always_comb begin
        dwell_d    = dwell_q;
        scan_idx_d = scan_idx_q;
        if (clr) begin
            dwell_d    = '0;
            scan_idx_d = '0;
        end else if (step_c) begin
            dwell_d    = '0;
            scan_idx_d = IN_W'(scan_idx_q + IN_W'(1));
        end else if (en) begin
            dwell_d    = DW_W'(dwell_q + DW_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q    <= '0;
            scan_idx_q <= '0;
        end else begin
            dwell_q    <= dwell_d;
            scan_idx_q <= scan_idx_d;
        end
    end

endmodule

// File: rtl/seq_decoder.sv
// Registered binary-to-2**IN_W decoder with valid/ready handshake,
// one-hot or thermometer output code, and an autonomous scan mode that walks
// a one-hot strobe across the outputs, DWELL cycles per position.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake carrying in_sel and in_mode
//   in_sel, in_mode     : binary select; 0 = one-hot, 1 = thermometer
//   scan_en             : level request for scan mode
//   out_valid/out_ready : output handshake (out_ready ignored in scan)
//   out_y               : registered decoded output
//   scan_idx            : registered scan position
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter  int unsigned IN_W  = 2,
    parameter  int unsigned DWELL = 4,
    localparam int unsigned OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sel,
    input  logic             in_mode,
    input  logic             scan_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic [IN_W-1:0]  scan_idx
);

    state_e           state_q, state_d;
    logic [OUT_W-1:0] out_y_q, out_y_d;
    logic             out_valid_q, out_valid_d;
    logic             ctr_clr, ctr_en, scan_step_c;
    logic             slot_free;
    logic [IN_W-1:0]  scan_idx_next;

    seq_decoder_scan_ctr #(
        .IN_W  (IN_W),
        .DWELL (DWELL)
    ) u_scan_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ctr_clr),
        .en       (ctr_en),
        .step_c   (scan_step_c),
        .scan_idx (scan_idx)
    );

    // Output register is free when empty or being drained this cycle.
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = rst_n && (state_q == DIRECT) && !scan_en && slot_free;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;

    // Position the strobe must show after this edge, so out_y tracks scan_idx.
    assign scan_idx_next = scan_step_c ? IN_W'(scan_idx + IN_W'(1)) : scan_idx;

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        unique case (state_q)
            DIRECT: begin
                if (scan_en && slot_free) begin
                    state_d     = SCAN;
                    ctr_clr     = 1'b1;
                    out_y_d     = OUT_W'(onehot('0));
                    out_valid_d = 1'b1;
                end else if (in_valid && in_ready) begin
                    out_y_d     = (in_mode == MODE_THERMO)
                                ? OUT_W'(thermo(MAX_IN_W'(in_sel)))
                                : OUT_W'(onehot(MAX_IN_W'(in_sel)));
                    out_valid_d = 1'b1;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            SCAN: begin
                if (!scan_en) begin
                    state_d     = DIRECT;
                    ctr_clr     = 1'b1;
                    out_y_d     = '0;
                    out_valid_d = 1'b0;
                end else begin
                    ctr_en      = 1'b1;
                    out_y_d     = OUT_W'(onehot(MAX_IN_W'(scan_idx_next)));
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = DIRECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DIRECT;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder (IN_W=2, DWELL=4) against a
// cycle-level behavioural model of the handshake and scan rules.
module tb_seq_decoder;

    localparam int IN_W  = 2;
    localparam int OUT_W = 4;
    localparam int DWELL = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sel;
    logic             in_mode;
    logic             scan_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_y;
    logic [IN_W-1:0]  scan_idx;

    int total = 0;
    int bad   = 0;

    // Model state: scan mode flag, cycles since scan entry, output register.
    bit               m_scan;
    int               m_k;
    logic             m_valid;
    logic [OUT_W-1:0] m_y;
    logic [IN_W-1:0]  m_idx;

    always #5 clk = ~clk;

    seq_decoder #(
        .IN_W  (IN_W),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_mode   (in_mode),
        .scan_en   (scan_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .scan_idx  (scan_idx)
    );

    function automatic logic [OUT_W-1:0] ref_code(input logic [IN_W-1:0] sel, input logic mode);
        logic [OUT_W-1:0] r;
        for (int i = 0; i < OUT_W; i++)
            r[i] = mode ? (i <= int'(sel)) : (i == int'(sel));
        return r;
    endfunction

    function automatic logic exp_ready();
        return rst_n && !m_scan && !scan_en && (!m_valid || out_ready);
    endfunction

    function automatic void model_update();
        logic rdy;
        rdy = exp_ready();
        if (!rst_n) begin
            m_scan = 0; m_k = 0; m_valid = 1'b0; m_y = '0;
        end else if (!m_scan) begin
            if (scan_en && (!m_valid || out_ready)) begin
                m_scan = 1; m_k = 0; m_valid = 1'b1;
            end else if (in_valid && rdy) begin
                m_valid = 1'b1; m_y = ref_code(in_sel, in_mode);
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end else if (!scan_en) begin
            m_scan = 0; m_k = 0; m_valid = 1'b0; m_y = '0;
        end else begin
            m_k++;
        end
        m_idx = m_scan ? IN_W'((m_k / DWELL) % OUT_W) : '0;
        if (m_scan) m_y = ref_code(m_idx, 1'b0);
    endfunction

    // One clock: model follows the edge, outputs then sampled at negedge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; scan_en = 1'b1; out_ready = 1'b1;
        in_sel = 2'd3; in_mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            total++;
            if ({in_ready, out_valid, out_y, scan_idx} !== 8'b0) begin
                bad++;
                $display("FAIL reset cyc%0d: got rdy=%b v=%b y=%b idx=%0d want all 0",
                         c, in_ready, out_valid, out_y, scan_idx);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0; scan_en = 1'b0;
        tick();
    endtask

    task automatic test_direct_sweep();
        out_ready = 1'b1; scan_en = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < OUT_W; s++) begin
                in_valid = 1'b1; in_sel = IN_W'(s); in_mode = m[0];
                #1;
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL sweep_ready m%0d s%0d: got %b want 1", m, s, in_ready);
                end
                tick();
                total++;
                if (out_valid !== 1'b1 || out_y !== ref_code(IN_W'(s), m[0]) || out_y !== m_y) begin
                    bad++;
                    $display("FAIL sweep m%0d s%0d: got v=%b y=%b want v=1 y=%b",
                             m, s, out_valid, out_y, ref_code(IN_W'(s), m[0]));
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_mode = 1'b0;
        tick();
        out_ready = 1'b0; in_sel = 2'd1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_y !== 4'b0100 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL backpressure cyc%0d: got rdy=%b v=%b y=%b want rdy=0 v=1 y=0100",
                         c, in_ready, out_valid, out_y);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: got rdy=%b want 1", in_ready);
        end
        tick();
        total++;
        if (out_y !== 4'b0010 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_next: got v=%b y=%b want v=1 y=0010", out_valid, out_y);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_scan();
        int err = 0;
        in_valid = 1'b1; scan_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_sel = IN_W'($urandom_range(0, 3)); in_mode = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (out_valid !== 1'b1 || scan_idx !== IN_W'((j / DWELL) % OUT_W)
                || out_y !== ref_code(IN_W'((j / DWELL) % OUT_W), 1'b0) || in_ready !== 1'b0) begin
                bad++; err++;
                $display("FAIL scan j%0d: got v=%b y=%b idx=%0d rdy=%b want idx=%0d",
                         j, out_valid, out_y, scan_idx, in_ready, (j / DWELL) % OUT_W);
            end
        end
        scan_en = 1'b0; in_valid = 1'b0;
        tick();
        total++;
        if ({out_valid, out_y, scan_idx} !== {m_valid, m_y, m_idx}) begin
            bad++;
            $display("FAIL scan_exit: got v=%b y=%b idx=%0d want 0", out_valid, out_y, scan_idx);
        end
        if (err != 0) $display("scan: %0d cycles differed", err);
    endtask

    task automatic test_scan_blocked();
        out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd3; in_mode = 1'b0;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; scan_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (out_y !== 4'b1000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL scan_blocked cyc%0d: got v=%b y=%b rdy=%b want v=1 y=1000 rdy=0",
                         c, out_valid, out_y, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_y !== 4'b0001 || out_valid !== 1'b1 || scan_idx !== 2'd0) begin
            bad++;
            $display("FAIL scan_entry: got v=%b y=%b idx=%0d want v=1 y=0001 idx=0",
                     out_valid, out_y, scan_idx);
        end
        scan_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        scan_en = 1'b1; in_valid = 1'b0;
        for (int j = 0; j < 9; j++) tick();
        total++;
        if (scan_idx !== 2'd2 || out_y !== 4'b0100) begin
            bad++;
            $display("FAIL mid_scan_pos: got idx=%0d y=%b want idx=2 y=0100", scan_idx, out_y);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if ({out_valid, out_y, scan_idx} !== 7'b0) begin
            bad++;
            $display("FAIL mid_scan_reset: got v=%b y=%b idx=%0d want 0", out_valid, out_y, scan_idx);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        scan_en = 1'b0; in_valid = 1'b1; in_sel = 2'd3; in_mode = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL exit_ready_scan: got rdy=%b want 0", in_ready);
        end
        tick();
        total++;
        if ({out_valid, out_y, scan_idx} !== 7'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL scan_exit2: got v=%b y=%b idx=%0d rdy=%b want v=0 y=0 idx=0 rdy=1",
                     out_valid, out_y, scan_idx, in_ready);
        end
        tick();
        total++;
        if (out_y !== 4'b1111 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL exit_thermo: got v=%b y=%b want v=1 y=1111", out_valid, out_y);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int err = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = IN_W'($urandom_range(0, 3));
            in_mode   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) scan_en = !scan_en;
            rst_n     = ($urandom_range(0, 99) != 0);
            #1;
            total++;
            if (in_ready !== exp_ready()) begin
                bad++; err++;
                $display("FAIL rand_ready c%0d: got %b want %b", c, in_ready, exp_ready());
            end
            tick();
            total++;
            if ({out_valid, out_y, scan_idx} !== {m_valid, m_y, m_idx}) begin
                bad++; err++;
                $display("FAIL rand c%0d: got v=%b y=%b idx=%0d want v=%b y=%b idx=%0d",
                         c, out_valid, out_y, scan_idx, m_valid, m_y, m_idx);
            end
        end
        rst_n = 1'b1; scan_en = 1'b0; in_valid = 1'b0;
        tick();
        if (err != 0) $display("random: %0d checks differed", err);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_mode = 1'b0;
        scan_en = 1'b0; out_ready = 1'b0;
        m_scan = 0; m_k = 0; m_valid = 1'b0; m_y = '0; m_idx = '0;
        @(negedge clk);
        test_reset();
        test_direct_sweep();
        test_backpressure();
        test_scan();
        test_scan_blocked();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
